console_wbuf: RTL
=================

# console_wbuf

Posted-write buffer between the core's data-bus port and the `console` device. It accepts byte-output and sim-control stores, queues them in order in a FIFO, and replays them to `console` at a programmable rate. The bus side never waits on console I/O pacing unless the queue is full. After a halt command is queued, the block seals itself so that no later store can reach the console.

## Interface
- `Depth`, 8: FIFO entries; power of two, ≥ 2.
- `DrainInterval`, 1: minimum cycles between issued console writes; ≥ 1.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: bus request.
- `we_i` in 1: bus write enable.
- `addr_i` in 32: bus address; only `[7:0]` is decoded.
- `wdata_i` in 32: bus write data.
- `gnt_o` out 1: request accepted this cycle (combinational).
- `dev_req_o` out 1: console request (registered).
- `dev_we_o` out 1: console write enable; equals `dev_req_o`.
- `dev_addr_o` out 32: console address; `{24'b0, entry addr}`.
- `dev_wdata_o` out 32: console write data.
- `level_o` out `$clog2(Depth)+1`: FIFO occupancy.
- `sealed_o` out 1: halt command accepted; further writes refused.

## Operation
- Decoded low-byte addresses: `0x04` CHAR, `0x08` CTRL.
- **Grant rules:**
  - Read (`req_i & !we_i`): `gnt_o=1`. The read is discarded, nothing is queued, and there is no response data.
  - Write to any address other than CHAR/CTRL: `gnt_o=1`, dropped, not queued.
  - Write to CHAR/CTRL: `gnt_o = !sealed_o & (level_o != Depth) & !rst_i`.
  - Push happens at the clock edge where `req_i & we_i & gnt_o` and the address is CHAR or CTRL.
- **Entry format:** `{addr_i[7:0], wdata_i[31:0]}`, 40 bits. Entries drain in strict FIFO order.
- **Seal state machine (ACCEPT → SEALED):**
  - Transition on a push to CTRL with `wdata_i[0]=1`. That entry is itself queued and drained normally.
  - A CTRL write with `wdata_i[0]=0` is queued without sealing.
  - SEALED exits only on reset.
  - In SEALED, CHAR/CTRL writes see `gnt_o=0` indefinitely. The bus master is expected to stop after halt.
- **Drain:**
  - Interval counter `ivl`, reset 0.
  - Each edge: if `ivl != 0`, decrement. Else if the FIFO is non-empty (pre-edge count), pop the head, register it onto the `dev_*` outputs with `dev_req_o=1`, and load `ivl = DrainInterval-1`.
  - Otherwise `dev_req_o=0`.
  - `dev_req_o` is high for exactly one cycle per entry. `console` always accepts, so there is no downstream backpressure.
- **Count arithmetic:**
  - `level_o` increments on push only, decrements on pop only, and is unchanged on a simultaneous push and pop.
  - Read and write pointers are `$clog2(Depth)` bits wide and wrap modulo `Depth`.
  - Because `gnt_o` uses the pre-edge count, a full FIFO refuses a push even if a pop happens on the same edge.

## Timing
- **Reset:** at the reset edge, `dev_req_o`, `dev_we_o`, `dev_addr_o`, `dev_wdata_o`, `level_o`, `sealed_o` and `ivl` all go to 0. FIFO contents are discarded.
- **Reset mid-drain:** any pending entries are lost. `dev_req_o` is 0 from the reset edge onward.
- **Latency:**
  - A write pushed at edge E into an empty FIFO with `ivl=0` is popped at E+1.
  - `dev_req_o` is high between E+1 and E+2, and `console` acts on it at E+2.
  - Minimum end-to-end latency is 2 edges.
- **Throughput:** one issue per `DrainInterval` cycles. With `DrainInterval=1`, issues are back-to-back every cycle.
- **Seal timing:** `sealed_o` rises at the edge that pushes the halt entry. `gnt_o` for writes is 0 in the very next cycle.
- **Halt ordering:** the console receives the halt only after every earlier-queued CHAR entry.

## Test plan
- **Single char** (Depth=8, DrainInterval=1). Stimulus: write addr `0x4`, data `0x41`, accepted at edge E. Required: `dev_req_o=1` only between E+1 and E+2, `dev_addr_o=0x4`, `dev_wdata_o=0x41`; `level_o` goes 0→1→0.
- **Fill and backpressure** (DrainInterval=16). Stimulus: 12 back-to-back CHAR writes, data `0..11`. Required: `level_o` peaks at 8; `gnt_o` is low while `level_o==8`; exactly one new write is accepted after each drain; console sees `0..11` in order with issues spaced exactly 16 cycles.
- **Seal.** Stimulus: CHAR `'H'`, then CTRL `0x1`, then CHAR `'X'`. Required: console sees `'H'`, then CTRL `0x1`; `sealed_o=1` from the CTRL push edge; `'X'` sees `gnt_o=0` and is never issued. A read issued while sealed sees `gnt_o=1` and leaves `level_o` unchanged.
- **Filtering.** Stimulus: a read to `0x4`, a write to `0x10`, and CTRL `0x0`. Required: all three see `gnt_o=1`; only the CTRL entry is issued; `sealed_o` stays 0.
- **Pacing** (DrainInterval=3). Stimulus: 3 back-to-back CHAR writes. Required: `dev_req_o` pulses exactly 3 cycles apart, in order.
- **Reset mid-drain** (DrainInterval=8). Stimulus: 3 entries queued, then `rst_i` high for one cycle. Required: `level_o=0`, `dev_req_o=0` and `sealed_o=0` after that edge; no further `dev_req_o` until new writes arrive.

Source files
------------

// File: rtl/console_wbuf.sv
// console_wbuf: posted-write buffer in front of the console device.
//
// The bus side stores CHAR (0x04) and CTRL (0x08) writes into an in-order
// FIFO without waiting on console pacing. A drain engine replays the entries
// to the console no faster than one every DrainInterval cycles. A CTRL write
// with bit 0 set is the halt command. Once it is queued the block seals, and
// no later store can reach the console until reset.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, we_i         bus request / write enable
//   addr_i, wdata_i     bus address (low byte decoded) / write data
//   gnt_o               request accepted this cycle (combinational)
//   dev_req_o/dev_we_o  one-cycle console write strobe (registered)
//   dev_addr_o          {24'b0, queued address byte}
//   dev_wdata_o         queued write data
//   level_o             FIFO occupancy, 0..Depth
//   sealed_o            halt command accepted; CHAR/CTRL writes refused
module console_wbuf #(
  parameter int Depth         = 8,
  parameter int DrainInterval = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  output logic                       gnt_o,
  output logic                       dev_req_o,
  output logic                       dev_we_o,
  output logic [31:0]                dev_addr_o,
  output logic [31:0]                dev_wdata_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       sealed_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  // Interval counter only needs to hold DrainInterval-1.
  localparam int IW = (DrainInterval > 1) ? $clog2(DrainInterval) : 1;

  localparam logic [7:0]    ADDR_CHAR  = 8'h04;
  localparam logic [7:0]    ADDR_CTRL  = 8'h08;
  localparam logic [LW-1:0] FULL_LVL   = LW'(Depth);
  localparam logic [IW-1:0] IVL_RELOAD = IW'(DrainInterval - 1);

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_SEALED = 1'b1
  } seal_st_e;

  seal_st_e        state_q, state_d;
  entry_t          mem [Depth];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic [IW-1:0]   ivl_q;

  logic            is_char, is_ctrl, is_dec;
  logic            room_ok, push, pop, halt_push;

  // Only the low address byte is decoded.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:8];

  assign is_char = (addr_i[7:0] == ADDR_CHAR);
  assign is_ctrl = (addr_i[7:0] == ADDR_CTRL);
  assign is_dec  = is_char | is_ctrl;

  // Acceptance uses the pre-edge count. A full FIFO refuses even when a pop
  // lands on the same edge.
  assign room_ok = (state_q == ST_ACCEPT) & (count_q != FULL_LVL) & !rst_i;

  // Reads and undecoded writes are acknowledged and dropped.
  assign gnt_o     = req_i & (!(we_i & is_dec) | room_ok);
  assign push      = req_i & we_i & is_dec & room_ok;
  assign halt_push = push & is_ctrl & wdata_i[0];
  assign pop       = (ivl_q == '0) & (count_q != '0);

  assign head      = mem[rd_ptr_q];

  // Seal FSM: the halt entry itself is still queued and drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: if (halt_push) state_d = ST_SEALED;
      ST_SEALED: state_d = ST_SEALED;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_ACCEPT;
    else       state_q <= state_d;
  end

  assign sealed_o = (state_q == ST_SEALED);

  // FIFO storage carries no reset. Stale data is never popped because the
  // pointers and the count are reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {addr_i[7:0], wdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign level_o = count_q;

  // Drain pacing. A pop reloads the gap counter, so consecutive issues are
  // DrainInterval cycles apart.
  always_ff @(posedge clk_i) begin
    if (rst_i)              ivl_q <= '0;
    else if (ivl_q != '0)   ivl_q <= ivl_q - IW'(1);
    else if (count_q != '0) ivl_q <= IVL_RELOAD;
  end

  // Console side. Address and data hold their last value between strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dev_req_o   <= 1'b0;
      dev_addr_o  <= '0;
      dev_wdata_o <= '0;
    end else if (pop) begin
      dev_req_o   <= 1'b1;
      dev_addr_o  <= {24'h0, head.addr};
      dev_wdata_o <= head.data;
    end else begin
      dev_req_o   <= 1'b0;
    end
  end

  assign dev_we_o = dev_req_o;

endmodule
